shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 97 +++++++++
 tb/tb_shift_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// shift_arbiter: round-robin arbiter over four requesters that captures the
// winner's parallel word and shifts it out LSB first, stallable by hold.
module shift_arbiter #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [BITS-1:0] d0,
    input  logic [BITS-1:0] d1,
    input  logic [BITS-1:0] d2,
    input  logic [BITS-1:0] d3,
    input  logic            hold,
    output logic [3:0]      gnt,
    output logic            sout,
    output logic            svalid,
    output logic            eos,
    output logic [1:0]      sid,
    output logic            busy
);
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          state_q, state_d;
    logic [BITS-1:0] word_q, word_d, word_sh, dsel;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      ptr_q, ptr_d, sid_q, sid_d, win;
    logic [3:0]      gnt_q, gnt_d;
    logic            found, capture, last;

    // search starts at ptr and wraps, so the last winner goes to the back
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!found && req[ptr_q + 2'(i)]) begin
                win   = ptr_q + 2'(i);
                found = 1'b1;
            end
        end
    end

    assign capture = (state_q == IDLE) && !hold && found;
    assign last    = (cnt_q == LAST);
    assign dsel    = (win == 2'd0) ? d0 : (win == 2'd1) ? d1 : (win == 2'd2) ? d2 : d3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = (state_q == IDLE) ? (capture ? SHIFT : IDLE)
                                    : ((!hold && last) ? IDLE : SHIFT);
    end

    always_comb begin
        word_d = capture ? dsel : word_q;
        sid_d  = capture ? win : sid_q;
        ptr_d  = capture ? win + 2'd1 : ptr_q;
        gnt_d  = capture ? 4'b0001 << win : 4'b0000;
        cnt_d  = capture ? '0
               : ((state_q == SHIFT) && !hold) ? (last ? '0 : cnt_q + 1'b1)
               : cnt_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_q <= '0;
            cnt_q  <= '0;
            ptr_q  <= '0;
            sid_q  <= '0;
            gnt_q  <= '0;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            ptr_q  <= ptr_d;
            sid_q  <= sid_d;
            gnt_q  <= gnt_d;
        end
    end

    always_comb begin
        word_sh = word_q >> cnt_q;
        svalid  = (state_q == SHIFT);
        sout    = svalid & word_sh[0];
        eos     = svalid & last;
        busy    = svalid;
        gnt     = gnt_q;
        sid     = sid_q;
    end
endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed stimulus with a frame scoreboard for the 8-bit
// build plus directed checks on a 1-bit build.
module tb_shift_arbiter;
    typedef struct {
        logic [1:0] sid;
        logic [7:0] word;
        int         cycles;
        int         eoss;
        int         gap;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req = 4'b0;
    logic [7:0] d0 = 8'h0, d1 = 8'h0, d2 = 8'h0, d3 = 8'h0;
    logic       hold = 1'b0;
    logic [3:0] gnt;
    logic       sout, svalid, eos, busy;
    logic [1:0] sid;

    logic [3:0] r1 = 4'b0;
    logic       w1 = 1'b0;
    logic [3:0] gnt1;
    logic       sout1, svalid1, eos1, busy1;
    logic [1:0] sid1;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    shift_arbiter #(.BITS(8)) dut (
        .clk(clk), .rst(rst), .req(req), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
        .hold(hold), .gnt(gnt), .sout(sout), .svalid(svalid), .eos(eos),
        .sid(sid), .busy(busy)
    );

    shift_arbiter #(.BITS(1)) dut1 (
        .clk(clk), .rst(rst), .req(r1), .d0(1'b0), .d1(w1), .d2(1'b0), .d3(1'b0),
        .hold(1'b0), .gnt(gnt1), .sout(sout1), .svalid(svalid1), .eos(eos1),
        .sid(sid1), .busy(busy1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic [7:0] w, input int c, input int e, input int g);
        exp_t x;
        x.sid = s; x.word = w; x.cycles = c; x.eoss = e; x.gap = g;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, n < 200, 1);
        @(posedge clk);
        #1;
    endtask

    // monitor: assembles each frame and compares against the scoreboard head
    initial begin
        bit         in_frame;
        int         idle, ncyc, neos, pos;
        logic [7:0] acc;
        exp_t       e;
        in_frame = 0; idle = 0; ncyc = 0; neos = 0; pos = 0; acc = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                in_frame = 0;
                idle = 0;
            end else if (svalid) begin
                if (!in_frame) begin
                    in_frame = 1; ncyc = 0; neos = 0; pos = 0; acc = '0;
                    if (exp_q.size() == 0) chk("unexpected_frame", 1, 0);
                    else begin
                        chk("gnt_onehot", gnt, 4'b0001 << exp_q[0].sid);
                        if (exp_q[0].gap >= 0) chk("idle_gap", idle, exp_q[0].gap);
                    end
                end else chk("gnt_pulse", gnt, 0);
                ncyc++;
                if (eos) neos++;
                if (!hold) begin
                    if (pos < 8) acc[pos] = sout;
                    pos++;
                end
                if (eos && !hold) begin
                    in_frame = 0;
                    idle = 0;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("frame_sid", sid, e.sid);
                        chk("frame_word", acc, e.word);
                        chk("frame_bits", pos, 8);
                        chk("frame_cycles", ncyc, e.cycles);
                        chk("frame_eos", neos, e.eoss);
                    end
                end
            end else begin
                idle++;
            end
        end
    end

    initial begin
        // reset state, before any clock edge
        req = 4'b1111;
        #1;
        chk("rst_svalid", svalid, 0);
        chk("rst_sout", sout, 0);
        chk("rst_eos", eos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_sid", sid, 0);
        @(posedge clk);
        #1;
        chk("rst_no_grant", {busy, gnt}, 0);
        req = 4'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // round robin with all requests held: 0,1,2,3,0 and one idle cycle between
        d0 = 8'h5A; d1 = 8'hC3; d2 = 8'h0F; d3 = 8'hE1;
        req = 4'b1111;
        push(2'd0, 8'h5A, 8, 1, -1);
        push(2'd1, 8'hC3, 8, 1, 1);
        push(2'd2, 8'h0F, 8, 1, 1);
        push(2'd3, 8'hE1, 8, 1, 1);
        push(2'd0, 8'h5A, 8, 1, 1);
        repeat (37) @(posedge clk);
        #1;
        req = 4'b0;
        wait_done("rr");

        // single frame A5
        d0 = 8'hA5;
        req = 4'b0001;
        push(2'd0, 8'hA5, 8, 1, -1);
        @(posedge clk);
        #1;
        req = 4'b0;
        d0 = 8'hFF;
        wait_done("single");

        // stall three cycles on bit 4 of 3C
        d1 = 8'h3C;
        req = 4'b0010;
        push(2'd1, 8'h3C, 11, 1, -1);
        @(posedge clk);
        #1;
        req = 4'b0;
        repeat (4) @(posedge clk);
        #1;
        hold = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        hold = 1'b0;
        wait_done("stall_mid");

        // stall two cycles on the last bit
        d3 = 8'h96;
        req = 4'b1000;
        push(2'd3, 8'h96, 10, 3, -1);
        @(posedge clk);
        #1;
        req = 4'b0;
        repeat (7) @(posedge clk);
        #1;
        hold = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        hold = 1'b0;
        @(negedge clk);
        chk("last_stall_busy", {busy, eos}, 2'b11);
        @(negedge clk);
        chk("last_stall_idle", busy, 0);
        wait_done("stall_last");

        // mid-frame asynchronous reset at bit 3
        d2 = 8'h0F;
        req = 4'b0001;
        push(2'd0, 8'h0F, 8, 1, -1);
        @(posedge clk);
        #1;
        req = 4'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_sout", sout, 1);
        #1;
        rst = 1'b0;
        #1;
        exp_q.delete();
        chk("async_svalid", svalid, 0);
        chk("async_sout", sout, 0);
        chk("async_eos", eos, 0);
        chk("async_busy", busy, 0);
        chk("async_ptr", dut.ptr_q, 0);
        d2 = 8'h81;
        req = 4'b0100;
        @(posedge clk);
        #1;
        chk("rst_hold_no_grant", {busy, gnt}, 0);
        @(negedge clk);
        rst = 1'b1;
        push(2'd2, 8'h81, 8, 1, -1);
        @(posedge clk);
        #1;
        req = 4'b0;
        wait_done("post_rst");

        // one-bit build: eos on the single valid cycle, then one idle cycle
        w1 = 1'b1;
        r1 = 4'b0010;
        @(negedge clk);
        chk("b1_pre", svalid1, 0);
        @(negedge clk);
        chk("b1_frame", {svalid1, sout1, eos1, gnt1, sid1}, {3'b111, 4'b0010, 2'd1});
        @(negedge clk);
        chk("b1_idle", {svalid1, gnt1}, 0);
        @(negedge clk);
        chk("b1_again", {svalid1, eos1, gnt1}, {2'b11, 4'b0010});
        r1 = 4'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
